pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Parametrised multi-channel PWM generator for the MCU top level. It replaces the single fixed PWM01 output with CH independent channels, each with its own period, duty, alignment mode and polarity. Shadow registers make updates glitch-free at period boundaries, and a shared prescaler divides CLK50M. It sits behind the MCU peripheral write port and drives PWM pins plus a per-channel period interrupt.

## Interface
Parameters:
- CH, 4: number of channels, 1..16.
- CW, 16: counter, period and duty width in bits.
- PW, 8: prescaler register width.

Ports:
- CLK50M  in  1  system clock; the only clock.
- RSTN  in  1  reset, synchronous, active-high. Sampled on CLK50M rising edge; asserted = reset.
- wr_en  in  1  register write strobe, single cycle.
- wr_ch  in  clog2(CH) (min 1)  target channel.
- wr_sel  in  2  register select: 0 = period, 1 = duty, 2 = ctrl, 3 = global prescaler. wr_ch is ignored for sel 3.
- wr_data  in  CW  write data:
  - ctrl uses bit0 en, bit1 center, bit2 pol.
  - prescaler uses bits [PW-1:0].
  - Unused bits are ignored.
- pwm_out  out  CH  PWM outputs, registered.
- period_irq  out  CH  one-cycle pulse per channel at each period boundary.

## Operation
- Prescaler:
  - Counter pc counts 0..PRESC, then wraps.
  - tick = (pc == PRESC). PRESC = 0 means a tick every cycle.
  - A prescaler write resets pc to 0 on the next cycle.
- Per-channel registers:
  - Shadow set: period_s, duty_s, en_s, center_s, pol_s. Written directly by wr_*.
  - Active set: period_a, duty_a, center_a, pol_a. Loaded from the shadow set at each boundary.
  - Enable (en) is not shadowed; it acts immediately.
- Disabled channel:
  - Counter held at 0, dir = up.
  - Active set tracks the shadow set every cycle.
  - pwm_out = pol_s (idle level). No irq.
- Edge mode (center = 0):
  - Counter counts up 0..period_a on ticks, then wraps to 0.
  - Period is period_a+1 ticks.
  - Raw output = (cnt < duty_a).
- Center mode (center = 1):
  - Counter counts up 0..period_a, then down period_a-1..1, then back to 0.
  - Period is 2·period_a ticks.
  - Raw output = (cnt < duty_a).
  - period_a = 0 behaves as a constant counter at 0; boundary occurs every tick.
- Boundary condition: a tick while the counter is about to return to 0.
  - Edge mode: cnt == period_a.
  - Center mode: down-count and cnt == 1, or period_a == 0.
  - At a boundary: active set loads from shadow, and period_irq[ch] pulses.
- Duty rules:
  - duty_a = 0 gives a constant raw 0.
  - duty_a > period_a gives a constant raw 1 (in center mode: duty_a > period_a).
- Output: pwm_out = raw XOR pol_a.
- Width: all comparisons are unsigned CW-bit. No overflow is possible; the counter never exceeds period_a.
- Simultaneous write and boundary on the same channel: the write wins. The active set loads the newly written value that cycle.
- Disabling mid-period: output goes to the idle level the next cycle and the counter clears. Re-enabling starts at cnt = 0 with the current shadow values.

## Timing
- Reset values: pwm_out = 0, period_irq = 0; all registers, counters and PRESC = 0; dir = up.
- While RSTN is high, outputs stay 0 regardless of wr_en.
- Counter updates on the CLK50M edge where tick = 1.
- pwm_out is registered: it reflects the counter value of the same edge, i.e. one cycle after the counter compare.
- period_irq is asserted for exactly one CLK50M cycle, coincident with the cycle in which cnt returns to 0.
- Write to shadow: visible one cycle after wr_en. It reaches pwm_out at the next boundary, or on the next cycle if the channel is disabled.
- Enable write: the first tick after en = 1 counts from 0. pwm_out is valid from the cycle after en is set.
- Reset asserted mid-period: all state clears on that edge, with no irq pulse.
- Channels are independent except for the shared tick. Boundaries of channels with equal settings are cycle-aligned.

## Test plan
- Edge mode: PRESC = 0, ch0 period = 9, duty = 3, en = 1 → pwm_out[0] runs high 3 cycles, low 7 cycles, repeating every 10 cycles; period_irq[0] pulses once per 10 cycles.
- Center mode: ch1 period = 4, duty = 2, center = 1 → counter sequence 0,1,2,3,4,3,2,1; pwm_out[1] high 3 contiguous cycles (1,0,1 across the wrap) per 8 cycles.
- Shadow update: ch0 running at period = 9, duty = 3; write duty = 7 mid-period → current period keeps high = 3; following period high = 7. Repeat with the write on the boundary cycle → the new duty applies immediately.
- Limits and polarity: duty = 0 → constant 0; duty = 12 with period = 9 → constant 1; pol = 1 inverts both; disabled with pol = 1 → idle level 1 and no irq.
- Prescaler: PRESC = 4, period = 1, duty = 1 → pwm_out high 5 cycles, low 5 cycles. Prescaler write mid-count restarts the pc phase.
- Reset mid-operation: assert RSTN for 1 cycle during high phase → next cycle all pwm_out = 0, irq = 0, registers cleared; re-program and verify the edge-mode case again.

Source files
------------

// File: rtl/pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// pwm_multi_ch
//   CH independent PWM channels sharing one prescaler tick. Each channel has
//   a shadow register set (written by the peripheral port) and an active set
//   (used by the counter). The active set reloads only at a period boundary,
//   so updates never produce runt pulses. Enable is not shadowed.
//
// Ports
//   CLK50M      system clock (rising edge)
//   RSTN        synchronous reset, active HIGH despite the name
//   wr_en       single-cycle register write strobe
//   wr_ch       target channel for period/duty/ctrl writes
//   wr_sel      0 = period, 1 = duty, 2 = ctrl {pol,center,en}, 3 = prescaler
//   wr_data     write data (prescaler uses [PW-1:0]; PW must not exceed CW)
//   pwm_out     registered PWM outputs, one per channel
//   period_irq  one-cycle pulse per channel in the cycle its counter returns to 0
// -----------------------------------------------------------------------------
module pwm_multi_ch #(
  parameter  int CH  = 4,
  parameter  int CW  = 16,
  parameter  int PW  = 8,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           CLK50M,
  input  logic           RSTN,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [1:0]     wr_sel,
  input  logic [CW-1:0]  wr_data,
  output logic [CH-1:0]  pwm_out,
  output logic [CH-1:0]  period_irq
);

  typedef enum logic [1:0] {
    SEL_PERIOD = 2'd0,
    SEL_DUTY   = 2'd1,
    SEL_CTRL   = 2'd2,
    SEL_PRESC  = 2'd3
  } sel_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef struct packed {
    logic [CW-1:0] period;
    logic [CW-1:0] duty;
    logic          center;
    logic          pol;
  } cfg_t;

  sel_e          sel;
  logic [PW-1:0] pc_q, presc_q;
  logic          tick, presc_wr;

  cfg_t          shadow_q [CH];
  cfg_t          shadow_d [CH];
  cfg_t          active_q [CH];
  cfg_t          active_d [CH];
  logic [CW-1:0] cnt_q    [CH];
  logic [CW-1:0] cnt_d    [CH];
  dir_e          dir_q    [CH];
  dir_e          dir_d    [CH];
  logic [CH-1:0] en_q, en_d, run, at_end, bnd, pwm_d;

  assign sel      = sel_e'(wr_sel);
  assign tick     = (pc_q == presc_q);
  assign presc_wr = wr_en && (sel == SEL_PRESC);

  // Next-state logic for every channel. The output is computed from the
  // next counter/active values so that pwm_out lines up with the counter
  // register rather than trailing it by a cycle.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: every variable gets a default before any branch, so no path
      // leaves it unassigned and no latch is inferred.
      shadow_d[i] = shadow_q[i];
      en_d[i]     = en_q[i];
      active_d[i] = active_q[i];
      cnt_d[i]    = cnt_q[i];
      dir_d[i]    = dir_q[i];

      if (wr_en && (wr_ch == CHW'(i))) begin
        case (sel)
          SEL_PERIOD: shadow_d[i].period = wr_data;
          SEL_DUTY:   shadow_d[i].duty   = wr_data;
          SEL_CTRL: begin
            en_d[i]            = wr_data[0];
            shadow_d[i].center = wr_data[1];
            shadow_d[i].pol    = wr_data[2];
          end
          default: ;
        endcase
      end

      // A channel counts only if it was enabled and is not being disabled
      // on this edge; otherwise it sits at 0 and mirrors its shadow set.
      run[i] = en_q[i] & en_d[i];

      // "About to return to 0". In center mode period 1 goes 0,1,0,1 so the
      // peak itself is the last count of the period.
      if (active_q[i].center)
        at_end[i] = (active_q[i].period == '0)
                 || (dir_q[i] == DIR_DOWN && cnt_q[i] == CW'(1))
                 || (dir_q[i] == DIR_UP && active_q[i].period == CW'(1)
                     && cnt_q[i] == CW'(1));
      else
        at_end[i] = (cnt_q[i] == active_q[i].period);

      bnd[i] = run[i] & tick & at_end[i];

      // Reload uses shadow_d so a write on the boundary cycle wins.
      if (!run[i] || bnd[i]) begin
        cnt_d[i]    = '0;
        dir_d[i]    = DIR_UP;
        active_d[i] = shadow_d[i];
      end else if (tick) begin
        if (!active_q[i].center) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end else if (dir_q[i] == DIR_DOWN) begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end else if (cnt_q[i] == active_q[i].period) begin
          dir_d[i] = DIR_DOWN;
          cnt_d[i] = cnt_q[i] - CW'(1);
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end

      // duty 0 and duty > period need no special case: the counter never
      // exceeds period, so the compare saturates naturally.
      pwm_d[i] = en_d[i] ? ((cnt_d[i] < active_d[i].duty) ^ active_d[i].pol)
                         : shadow_d[i].pol;
    end
  end

  always_ff @(posedge CLK50M) begin
    if (RSTN) begin
      pc_q       <= '0;
      presc_q    <= '0;
      en_q       <= '0;
      pwm_out    <= '0;
      period_irq <= '0;
      // NOTE: these per-channel arrays are flop banks, not RAM, and must come
      // out of reset in a known state, so each entry is cleared explicitly.
      for (int i = 0; i < CH; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        cnt_q[i]    <= '0;
        dir_q[i]    <= DIR_UP;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (presc_wr) begin
        presc_q <= wr_data[PW-1:0];
        pc_q    <= '0;
      end else begin
        pc_q <= tick ? '0 : pc_q + PW'(1);
      end
      en_q       <= en_d;
      pwm_out    <= pwm_d;
      period_irq <= bnd;
      for (int i = 0; i < CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        cnt_q[i]    <= cnt_d[i];
        dir_q[i]    <= dir_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_ch
//   Scoreboard bench for pwm_multi_ch (CH=4, CW=16, PW=8). Every applied clock
//   edge pushes the expected {pwm_out, period_irq} from a reference model that
//   tracks each channel as a phase index within its period; a monitor pops and
//   compares on the falling edge. Directed windows check the waveform shapes.
// -----------------------------------------------------------------------------
module tb_pwm_multi_ch;

  localparam int CH = 4;

  logic        CLK50M = 1'b0;
  logic        RSTN;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;
  logic [3:0]  pwm_out;
  logic [3:0]  period_irq;

  always #5 CLK50M = ~CLK50M;

  pwm_multi_ch #(.CH(CH), .CW(16), .PW(8)) dut (
    .CLK50M     (CLK50M),
    .RSTN       (RSTN),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .period_irq (period_irq)
  );

  typedef struct packed {
    logic [3:0] pwm;
    logic [3:0] irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------- reference model ----------------
  int m_pc, m_presc;
  int s_per [CH], s_duty [CH], a_per [CH], a_duty [CH], k [CH];
  bit s_en [CH], s_cen [CH], s_pol [CH], a_cen [CH], a_pol [CH];

  // Ticks in one period of the active configuration.
  function automatic int plen(input int c);
    if (a_cen[c]) return (a_per[c] == 0) ? 1 : 2 * a_per[c];
    return a_per[c] + 1;
  endfunction

  // Counter value implied by the phase index.
  function automatic int pcnt(input int c);
    if (a_cen[c] && k[c] > a_per[c]) return 2 * a_per[c] - k[c];
    return k[c];
  endfunction

  task automatic load_active(input int c);
    a_per[c]  = s_per[c];
    a_duty[c] = s_duty[c];
    a_cen[c]  = s_cen[c];
    a_pol[c]  = s_pol[c];
  endtask

  task automatic model_edge(input bit rst, input bit we, input int ch,
                            input int sel, input logic [15:0] data);
    exp_t e;
    bit   tk;
    bit   en_old;
    e = '0;
    if (rst) begin
      m_pc = 0;
      m_presc = 0;
      for (int c = 0; c < CH; c++) begin
        s_per[c] = 0; s_duty[c] = 0; s_en[c] = 0; s_cen[c] = 0; s_pol[c] = 0;
        k[c] = 0;
        load_active(c);
      end
    end else begin
      tk = (m_pc == m_presc);
      if (we && sel == 3) begin
        m_pc    = 0;
        m_presc = int'(data[7:0]);
      end else begin
        m_pc = tk ? 0 : m_pc + 1;
      end
      for (int c = 0; c < CH; c++) begin
        en_old = s_en[c];
        if (we && sel != 3 && ch == c) begin
          case (sel)
            0: s_per[c]  = int'(data);
            1: s_duty[c] = int'(data);
            2: begin
              s_en[c]  = data[0];
              s_cen[c] = data[1];
              s_pol[c] = data[2];
            end
            default: ;
          endcase
        end
        if (!s_en[c] || !en_old) begin
          k[c] = 0;
          load_active(c);
        end else if (tk) begin
          if (k[c] == plen(c) - 1) begin
            k[c] = 0;
            load_active(c);
            e.irq[c] = 1'b1;
          end else begin
            k[c] = k[c] + 1;
          end
        end
        e.pwm[c] = s_en[c] ? ((pcnt(c) < a_duty[c]) ^ a_pol[c]) : s_pol[c];
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- driver helpers ----------------
  task automatic step(input bit rst, input bit we, input int ch, input int sel,
                      input logic [15:0] data);
    RSTN    = rst;
    wr_en   = we;
    wr_ch   = 2'(ch);
    wr_sel  = 2'(sel);
    wr_data = data;
    model_edge(rst, we, ch, sel, data);
    @(posedge CLK50M);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 16'h0000);
  endtask

  task automatic wr(input int ch, input int sel, input logic [15:0] data);
    step(1'b0, 1'b1, ch, sel, data);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic window(input int c, input int n, output int highs, output int irqs);
    highs = 0;
    irqs  = 0;
    for (int i = 0; i < n; i++) begin
      idle();
      highs += int'(pwm_out[c]);
      irqs  += int'(period_irq[c]);
    end
  endtask

  // Idle until the next edge is a boundary for channel c (bounded).
  task automatic wait_boundary(input int c, input string name);
    int n;
    n = 0;
    while (!(s_en[c] && m_pc == m_presc && k[c] == plen(c) - 1) && n < 400) begin
      idle();
      n++;
    end
    if (n >= 400) check({name, "_timeout"}, 1, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    @(posedge CLK50M);
    forever begin
      @(negedge CLK50M);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (pwm_out !== e.pwm || period_irq !== e.irq) begin
          n_err++;
          $display("FAIL scoreboard t=%0t: pwm_out=%b period_irq=%b, expected pwm_out=%b period_irq=%b",
                   $time, pwm_out, period_irq, e.pwm, e.irq);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int h, q, n;

    // Reset with a write attempted during it: outputs must stay 0.
    step(1'b1, 1'b0, 0, 0, 16'h0000);
    step(1'b1, 1'b1, 3, 2, 16'h0005);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_irq", int'(period_irq), 0);
    idle();
    check("post_reset_pwm", int'(pwm_out), 0);

    // Edge mode: period 9, duty 3 -> 3 high / 7 low, one irq per 10.
    wr(0, 0, 16'd9);
    wr(0, 1, 16'd3);
    wr(0, 2, 16'h0001);
    window(0, 10, h, q);
    check("edge_high", h, 3);
    check("edge_irq", q, 1);

    // Center mode: period 4, duty 2 -> 3 high per 8 cycles.
    wr(1, 0, 16'd4);
    wr(1, 1, 16'd2);
    wr(1, 2, 16'h0003);
    window(1, 16, h, q);
    check("center_high", h, 6);
    check("center_irq", q, 2);

    // Shadow update mid-period: current period keeps duty 3.
    n = 0;
    while (k[0] != 4 && n < 50) begin idle(); n++; end
    wr(0, 1, 16'd7);
    check("shadow_hold", int'(pwm_out[0]), 0);
    wait_boundary(0, "shadow");
    window(0, 10, h, q);
    check("shadow_new_high", h, 7);

    // Write on the boundary cycle applies immediately.
    wait_boundary(0, "bnd_wr");
    wr(0, 1, 16'd2);
    h = int'(pwm_out[0]);
    check("bnd_wr_irq", int'(period_irq[0]), 1);
    window(0, 9, n, q);
    check("bnd_wr_high", h + n, 2);

    // Limits and polarity on ch2.
    wr(2, 0, 16'd9);
    wr(2, 1, 16'd0);
    wr(2, 2, 16'h0001);
    window(2, 10, h, q);
    check("duty0_high", h, 0);
    check("duty0_irq", q, 1);
    wr(2, 1, 16'd12);
    wait_boundary(2, "duty12");
    idle();
    window(2, 10, h, q);
    check("duty12_high", h + int'(pwm_out[2]) - int'(pwm_out[2]), 10);
    wr(2, 2, 16'h0005);
    wait_boundary(2, "pol");
    idle();
    window(2, 10, h, q);
    check("pol_inv_high", h, 0);

    // Disabled with pol = 1: idle level 1, no irq.
    wr(3, 2, 16'h0004);
    check("idle_pol", int'(pwm_out[3]), 1);
    window(3, 12, h, q);
    check("idle_high", h, 12);
    check("idle_irq", q, 0);

    // Prescaler 4, period 1, duty 1 -> 5 high / 5 low.
    wr(0, 3, 16'd4);
    wr(0, 0, 16'd1);
    wr(0, 1, 16'd1);
    wait_boundary(0, "presc");
    idle();
    window(0, 20, h, q);
    check("presc_high", h, 10);
    check("presc_irq", q, 2);
    n = 0;
    while (m_pc != 2 && n < 20) begin idle(); n++; end
    wr(1, 3, 16'h3304);   // upper bits beyond PW are ignored
    window(0, 20, h, q);

    // Reset for one cycle during the high phase.
    n = 0;
    while (pwm_out[0] != 1'b1 && n < 50) begin idle(); n++; end
    check("pre_reset_high", int'(pwm_out[0]), 1);
    step(1'b1, 1'b0, 0, 0, 16'h0000);
    check("midreset_pwm", int'(pwm_out), 0);
    check("midreset_irq", int'(period_irq), 0);
    idle();
    check("midreset_cleared", int'(pwm_out), 0);
    wr(0, 0, 16'd9);
    wr(0, 1, 16'd3);
    wr(0, 2, 16'h0001);
    window(0, 10, h, q);
    check("rerun_high", h, 3);
    check("rerun_irq", q, 1);

    // Randomized traffic, checked by the scoreboard every cycle.
    for (int i = 0; i < 3000; i++) begin
      int r, ch, sel;
      logic [15:0] d;
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        step(1'b1, 1'b0, 0, 0, 16'h0000);
      end else if (r < 200) begin
        ch  = int'($urandom_range(0, 3));
        sel = int'($urandom_range(0, 3));
        case (sel)
          0:       d = 16'($urandom_range(0, 7));
          1:       d = 16'($urandom_range(0, 9));
          2:       d = 16'($urandom);
          default: d = {8'($urandom), 8'($urandom_range(0, 2))};
        endcase
        wr(ch, sel, d);
      end else begin
        idle();
      end
    end

    @(negedge CLK50M);
    #1;
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
